// File: rtl/lcm_pkg.sv
// Shared types and constants for the LCM custom instruction.
package lcm_pkg;

    typedef enum logic [2:0] {
        IDLE,
        GCD_REQ,
        GCD_WAIT,
        DIV,
        MUL,
        DONE
    } state_e;

    // One quotient/product bit per cycle, so the default width is also the DIV and MUL cycle count.
    localparam int ITER_CNT = 32;

    // Saturation pattern, sliced to W; wide enough for any W up to 64.
    localparam logic [63:0] SAT_ONES = '1;

endpackage

// File: rtl/seq_divider.sv
// Restoring divider: W cycles after start, one quotient bit per enabled cycle.
// done marks the cycle of the final step; quotient is complete from the next cycle on.
module seq_divider
    import lcm_pkg::*;
#(
    parameter int W = ITER_CNT
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         clk_en,
    input  logic         start,
    input  logic [W-1:0] dividend,
    input  logic [W-1:0] divisor,
    output logic         done,
    output logic [W-1:0] quotient
);

    localparam int CNT_W = (W > 1) ? $clog2(W) : 1;

    logic             busy_q, busy_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [W-1:0]     rem_q, rem_d;
    logic [W-1:0]     quo_q, quo_d;
    logic [W-1:0]     dsr_q, dsr_d;

    logic [W:0]       rem_sh;
    logic             ge;

    assign rem_sh   = {rem_q, quo_q[W-1]};
    assign ge       = (rem_sh >= {1'b0, dsr_q});
    assign done     = busy_q && (cnt_q == '0);
    assign quotient = quo_q;

    always_comb begin
        busy_d = busy_q;
        cnt_d  = cnt_q;
        rem_d  = rem_q;
        quo_d  = quo_q;
        dsr_d  = dsr_q;
        if (start) begin
            busy_d = 1'b1;
            cnt_d  = CNT_W'(W - 1);
            rem_d  = '0;
            quo_d  = dividend;
            dsr_d  = divisor;
        end else if (busy_q) begin
            // The remainder is always below the divisor, so it fits back into W bits.
            rem_d = W'(ge ? (rem_sh - {1'b0, dsr_q}) : rem_sh);
            quo_d = {quo_q[W-2:0], ge};
            if (cnt_q == '0) begin
                busy_d = 1'b0;
            end else begin
                cnt_d = cnt_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            busy_q <= 1'b0;
            cnt_q  <= '0;
            rem_q  <= '0;
            quo_q  <= '0;
            dsr_q  <= '0;
        end else if (clk_en) begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
            rem_q  <= rem_d;
            quo_q  <= quo_d;
            dsr_q  <= dsr_d;
        end
    end

endmodule

// File: rtl/lcm_ci.sv
// LCM custom instruction: lcm(a,b) = (a / gcd) * b, gcd supplied by an external engine.
//   state    | meaning
//   IDLE     | waiting for start
//   GCD_REQ  | gcd_start pulse to the engine
//   GCD_WAIT | waiting for gcd_done (optional timeout)
//   DIV      | q = a / g, W cycles in seq_divider
//   MUL      | p = q * b, W shift-add cycles
//   DONE     | done pulse, result and ovf presented
module lcm_ci
    import lcm_pkg::*;
#(
    parameter int W           = ITER_CNT,
    parameter int GCD_TIMEOUT = 0
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         clk_en,
    input  logic         start,
    input  logic [W-1:0] dataa,
    input  logic [W-1:0] datab,
    output logic         done,
    output logic [W-1:0] result,
    output logic         ovf,
    output logic         gcd_start,
    output logic [W-1:0] gcd_dataa,
    output logic [W-1:0] gcd_datab,
    input  logic         gcd_done,
    input  logic [W-1:0] gcd_result
);

    localparam int CNT_W = (W > 1) ? $clog2(W) : 1;
    localparam int TMO_W = 32;

    state_e           state_q, state_d;
    logic [W-1:0]     a_q, a_d;
    logic [W-1:0]     b_q, b_d;
    logic [2*W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0] mul_cnt_q, mul_cnt_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             done_q, done_d;
    logic             gcd_start_q, gcd_start_d;
    logic [W-1:0]     result_q, result_d;
    logic             ovf_q, ovf_d;

    logic             div_start;
    logic             div_done;
    logic [W-1:0]     div_quo;
    logic [2*W-1:0]   acc_nxt;

    seq_divider #(.W(W)) u_div (
        .clk      (clk),
        .reset_n  (reset_n),
        .clk_en   (clk_en),
        .start    (div_start),
        .dividend (a_q),
        .divisor  (gcd_result),
        .done     (div_done),
        .quotient (div_quo)
    );

    // MSB-first shift-add: quotient stays stable in the divider for the whole MUL phase.
    assign acc_nxt = (acc_q << 1) + (div_quo[mul_cnt_q] ? {{W{1'b0}}, b_q} : '0);

    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        acc_d       = acc_q;
        mul_cnt_d   = mul_cnt_q;
        tmo_d       = tmo_q;
        done_d      = 1'b0;
        gcd_start_d = 1'b0;
        result_d    = result_q;
        ovf_d       = ovf_q;
        div_start   = 1'b0;
        if (start) begin
            a_d   = dataa;
            b_d   = datab;
            ovf_d = 1'b0;
            if ((dataa == '0) || (datab == '0)) begin
                state_d  = DONE;
                done_d   = 1'b1;
                result_d = '0;
            end else begin
                state_d     = GCD_REQ;
                gcd_start_d = 1'b1;
            end
        end else begin
            case (state_q)
                IDLE: ;
                GCD_REQ: begin
                    state_d = GCD_WAIT;
                    tmo_d   = TMO_W'(GCD_TIMEOUT - 1);
                end
                GCD_WAIT: begin
                    if (gcd_done) begin
                        div_start = 1'b1;
                        state_d   = DIV;
                    end else if ((GCD_TIMEOUT != 0) && (tmo_q == '0)) begin
                        state_d  = DONE;
                        done_d   = 1'b1;
                        result_d = '0;
                        ovf_d    = 1'b1;
                    end else begin
                        tmo_d = tmo_q - 1'b1;
                    end
                end
                DIV: begin
                    if (div_done) begin
                        state_d   = MUL;
                        acc_d     = '0;
                        mul_cnt_d = CNT_W'(W - 1);
                    end
                end
                MUL: begin
                    acc_d     = acc_nxt;
                    mul_cnt_d = mul_cnt_q - 1'b1;
                    if (mul_cnt_q == '0) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                        if (acc_nxt[2*W-1:W] == '0) begin
                            result_d = acc_nxt[W-1:0];
                            ovf_d    = 1'b0;
                        end else begin
                            result_d = SAT_ONES[W-1:0];
                            ovf_d    = 1'b1;
                        end
                    end
                end
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            acc_q       <= '0;
            mul_cnt_q   <= '0;
            tmo_q       <= '0;
            done_q      <= 1'b0;
            gcd_start_q <= 1'b0;
            result_q    <= '0;
            ovf_q       <= 1'b0;
        end else if (clk_en) begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            acc_q       <= acc_d;
            mul_cnt_q   <= mul_cnt_d;
            tmo_q       <= tmo_d;
            done_q      <= done_d;
            gcd_start_q <= gcd_start_d;
            result_q    <= result_d;
            ovf_q       <= ovf_d;
        end
    end

    assign done      = done_q;
    assign result    = result_q;
    assign ovf       = ovf_q;
    assign gcd_start = gcd_start_q;
    assign gcd_dataa = a_q;
    assign gcd_datab = b_q;

endmodule

// File: tb/tb_lcm_ci.sv
// Scoreboard bench for lcm_ci: stimulus queues expected completions, a monitor checks each done.
module tb_lcm_ci;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         clk_en = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] dataa = '0;
    logic [W-1:0] datab = '0;
    logic         done;
    logic [W-1:0] result;
    logic         ovf;
    logic         gcd_start;
    logic [W-1:0] gcd_dataa;
    logic [W-1:0] gcd_datab;
    logic         gcd_done = 1'b0;
    logic [W-1:0] gcd_result = '0;

    lcm_ci #(.W(W), .GCD_TIMEOUT(0)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .clk_en     (clk_en),
        .start      (start),
        .dataa      (dataa),
        .datab      (datab),
        .done       (done),
        .result     (result),
        .ovf        (ovf),
        .gcd_start  (gcd_start),
        .gcd_dataa  (gcd_dataa),
        .gcd_datab  (gcd_datab),
        .gcd_done   (gcd_done),
        .gcd_result (gcd_result)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail = 0;
    int n_gstart = 0;
    int start_cyc = 0;
    int gdone_cyc = 0;
    logic [W-1:0] exp_a = '0;
    logic [W-1:0] exp_b = '0;
    logic [W-1:0] eng_g = '0;
    bit           eng_extra = 1'b0;

    typedef struct {
        logic [W-1:0] res;
        logic         ovf;
        int           lat;
        bit           from_start;
    } exp_t;
    exp_t exp_q[$];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, got, want);
        end
    endtask

    task automatic push(input logic [W-1:0] res, input logic o, input int lat, input bit fs);
        exp_t e;
        e.res = res;
        e.ovf = o;
        e.lat = lat;
        e.from_start = fs;
        exp_q.push_back(e);
    endtask

    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] g);
        @(posedge clk);
        #1;
        exp_a = a;
        exp_b = b;
        eng_g = g;
        dataa = a;
        datab = b;
        start = 1'b1;
        start_cyc = cyc;
        @(posedge clk);
        #1;
        start = 1'b0;
        dataa = ~a;
        datab = ~b;
    endtask

    task automatic wait_gdone();
        bit seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            if (gcd_done === 1'b1) seen = 1'b1;
        end
        check("gcd_done_seen", 64'(seen), 64'(1));
    endtask

    task automatic drain(input int max_cyc);
        for (int i = 0; i < max_cyc && exp_q.size() != 0; i++) @(negedge clk);
        check("drain_pending", 64'(exp_q.size()), 64'(0));
        exp_q.delete();
    endtask

    // Monitor: compare every done pulse with the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (done === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_done: done=1 result=%0h ovf=%0b, none expected", result, ovf);
                end else begin
                    e = exp_q.pop_front();
                    check("result", 64'(result), 64'(e.res));
                    check("ovf", 64'(ovf), 64'(e.ovf));
                    check("latency", 64'(cyc - (e.from_start ? start_cyc : gdone_cyc)), 64'(e.lat));
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (gcd_start === 1'b1) n_gstart++;
        end
    end

    // GCD engine model: answers two cycles after the request, optionally with a stray extra pulse.
    initial begin
        forever begin
            @(negedge clk);
            if (gcd_start === 1'b1) begin
                check("gcd_dataa", 64'(gcd_dataa), 64'(exp_a));
                check("gcd_datab", 64'(gcd_datab), 64'(exp_b));
                repeat (2) @(posedge clk);
                #1;
                check("gcd_dataa_hold", 64'(gcd_dataa), 64'(exp_a));
                gcd_result = eng_g;
                gcd_done = 1'b1;
                gdone_cyc = cyc;
                @(posedge clk);
                #1;
                gcd_done = 1'b0;
                gcd_result = '0;
                if (eng_extra) begin
                    repeat (3) @(posedge clk);
                    #1;
                    gcd_result = 32'd1;
                    gcd_done = 1'b1;
                    @(posedge clk);
                    #1;
                    gcd_done = 1'b0;
                    gcd_result = '0;
                end
            end
        end
    end

    initial begin
        int gs;
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(negedge clk);
        check("rst_done", 64'(done), 64'(0));
        check("rst_result", 64'(result), 64'(0));
        check("rst_ovf", 64'(ovf), 64'(0));
        check("rst_gcd_start", 64'(gcd_start), 64'(0));

        // lcm(4,6): q = 4/2 = 2, p = 2*6 = 12
        gs = n_gstart;
        push(32'd12, 1'b0, 65, 1'b0);
        issue(32'd4, 32'd6, 32'd2);
        drain(120);
        check("gcd_start_pulses", 64'(n_gstart - gs), 64'(1));

        // zero operand: immediate result 0, engine untouched
        gs = n_gstart;
        push(32'd0, 1'b0, 1, 1'b1);
        issue(32'd0, 32'd7, 32'd0);
        drain(10);
        repeat (5) @(negedge clk);
        check("gcd_start_zero", 64'(n_gstart - gs), 64'(0));

        // product exceeds 32 bits: saturate
        push(32'hFFFF_FFFF, 1'b1, 65, 1'b0);
        issue(32'hFFFF_0000, 32'h0000_FFFF, 32'd1);
        drain(120);
        repeat (3) @(negedge clk);
        check("ovf_held", 64'(ovf), 64'(1));
        check("result_held", 64'(result), 64'hFFFF_FFFF);

        // zero in b; new start clears ovf
        push(32'd0, 1'b0, 1, 1'b1);
        issue(32'd12, 32'd0, 32'd0);
        drain(10);

        // clk_en low for 5 cycles inside MUL stretches latency to 70
        push(32'd7, 1'b0, 70, 1'b0);
        issue(32'd7, 32'd7, 32'd7);
        wait_gdone();
        repeat (40) @(posedge clk);
        #1;
        clk_en = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        clk_en = 1'b1;
        drain(120);

        // abort (4,6) during DIV with (3,5): only one done, result 15
        issue(32'd4, 32'd6, 32'd2);
        wait_gdone();
        repeat (10) @(posedge clk);
        push(32'd15, 1'b0, 65, 1'b0);
        issue(32'd3, 32'd5, 32'd1);
        drain(150);

        // stray gcd_done during DIV must be ignored: lcm(21,6) = 42
        eng_extra = 1'b1;
        push(32'd42, 1'b0, 65, 1'b0);
        issue(32'd21, 32'd6, 32'd3);
        drain(120);
        eng_extra = 1'b0;

        // reset during MUL: no done afterwards, result cleared
        issue(32'd9, 32'd6, 32'd3);
        wait_gdone();
        repeat (40) @(posedge clk);
        #1;
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(negedge clk);
        check("mulrst_result", 64'(result), 64'(0));
        check("mulrst_done", 64'(done), 64'(0));
        check("mulrst_ovf", 64'(ovf), 64'(0));
        repeat (80) @(negedge clk);
        check("final_pending", 64'(exp_q.size()), 64'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
